// File: rtl/video_frame_monitor.sv
// Per-frame video timing monitor: measures sync/blank geometry, counts frames and
// computes a CRC-16-CCITT over the active pixels, locking once two frames agree.
module video_frame_monitor #(
  parameter int C_COMPONENT_DEPTH = 4,
  parameter int C_CHANNELS        = 3,
  parameter int C_HCOUNT_WIDTH    = 12,
  parameter int C_VCOUNT_WIDTH    = 11,
  parameter int C_HSYNC_ACTIVE    = 0,
  parameter int C_VSYNC_ACTIVE    = 0
) (
  input  logic                                  pixel_clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic [C_CHANNELS*C_COMPONENT_DEPTH-1:0] pixel,
  input  logic                                  hsync,
  input  logic                                  vsync,
  input  logic                                  hblank,
  input  logic                                  vblank,
  output logic [C_HCOUNT_WIDTH-1:0]             h_total,
  output logic [C_HCOUNT_WIDTH-1:0]             h_active,
  output logic [C_VCOUNT_WIDTH-1:0]             v_total,
  output logic [C_VCOUNT_WIDTH-1:0]             v_active,
  output logic [15:0]                           frame_crc,
  output logic [15:0]                           frame_count,
  output logic                                  frame_done,
  output logic                                  locked,
  output logic                                  timing_error
);

  localparam int PW = C_CHANNELS * C_COMPONENT_DEPTH;
  localparam int HW = C_HCOUNT_WIDTH;
  localparam int VW = C_VCOUNT_WIDTH;
  localparam logic HS_ACT = (C_HSYNC_ACTIVE != 0);
  localparam logic VS_ACT = (C_VSYNC_ACTIVE != 0);
  localparam logic [HW-1:0] H_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] V_ONE = {{(VW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {SEARCH, MEASURE, CONFIRM, LOCKED} state_t;

  function automatic logic [HW-1:0] h_inc(input logic [HW-1:0] x);
    return (x == '1) ? x : x + H_ONE;
  endfunction

  function automatic logic [VW-1:0] v_inc(input logic [VW-1:0] x);
    return (x == '1) ? x : x + V_ONE;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [PW-1:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = PW - 1; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [PW-1:0] pixel_q;
  logic hsync_q, hs_prev_q, vsync_q, vs_prev_q, hblank_q, vblank_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q   <= '0;
      hsync_q   <= !HS_ACT;
      hs_prev_q <= !HS_ACT;
      vsync_q   <= !VS_ACT;
      vs_prev_q <= !VS_ACT;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
    end else begin
      pixel_q   <= pixel;
      hsync_q   <= hsync;
      hs_prev_q <= hsync_q;
      vsync_q   <= vsync;
      vs_prev_q <= vsync_q;
      hblank_q  <= hblank;
      vblank_q  <= vblank;
    end
  end

  logic hs_edge, vs_edge, pix_active;
  assign hs_edge    = (hsync_q == HS_ACT) && (hs_prev_q != HS_ACT);
  assign vs_edge    = (vsync_q == VS_ACT) && (vs_prev_q != VS_ACT);
  assign pix_active = !hblank_q && !vblank_q;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d, act_cnt_q, act_cnt_d, h_cand_q, h_cand_d;
  logic [HW-1:0] h_act_cand_q, h_act_cand_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_act_q, v_act_d;
  logic          have_act_q, have_act_d, irregular_q, irregular_d;
  logic [15:0]   crc_q, crc_d;
  logic [HW-1:0] ref_h_total_q, ref_h_total_d, ref_h_active_q, ref_h_active_d;
  logic [VW-1:0] ref_v_total_q, ref_v_total_d, ref_v_active_q, ref_v_active_d;
  logic          ref_bad_q, ref_bad_d;
  logic [HW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [VW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic [15:0]   frame_crc_q, frame_crc_d, frame_count_q, frame_count_d;
  logic          frame_done_q, frame_done_d, locked_q, locked_d, timing_error_q, timing_error_d;

  // Frame totals including a line that closes in the same cycle as the frame.
  logic [HW-1:0] fin_h_total, fin_h_active;
  logic [VW-1:0] fin_v_total, fin_v_active;
  logic [15:0]   fin_crc;
  logic          fin_irregular, fin_bad, line_has_act, matches_ref;

  always_comb begin
    line_has_act  = hs_edge && (act_cnt_q != '0);
    fin_v_total   = hs_edge ? v_inc(v_cnt_q) : v_cnt_q;
    fin_h_total   = (v_cnt_q == '0) ? h_cnt_q : h_cand_q;
    fin_irregular = irregular_q || (hs_edge && (v_cnt_q != '0) && (h_cnt_q != h_cand_q));
    fin_h_active  = have_act_q ? h_act_cand_q : (line_has_act ? act_cnt_q : '0);
    fin_v_active  = line_has_act ? v_inc(v_act_q) : v_act_q;
    fin_crc       = pix_active ? crc_step(crc_q, pixel_q) : crc_q;
    fin_bad       = fin_irregular || (fin_h_total == '1) || (fin_h_active == '1) ||
                    (fin_v_total == '1) || (fin_v_active == '1);
    matches_ref   = !fin_bad && !ref_bad_q &&
                    (fin_h_total == ref_h_total_q) && (fin_h_active == ref_h_active_q) &&
                    (fin_v_total == ref_v_total_q) && (fin_v_active == ref_v_active_q);
  end

  always_comb begin
    h_cnt_d      = hs_edge ? H_ONE : h_inc(h_cnt_q);
    act_cnt_d    = hs_edge ? (pix_active ? H_ONE : '0) : (pix_active ? h_inc(act_cnt_q) : act_cnt_q);
    v_cnt_d      = vs_edge ? '0 : fin_v_total;
    v_act_d      = vs_edge ? '0 : fin_v_active;
    irregular_d  = vs_edge ? 1'b0 : fin_irregular;
    h_cand_d     = h_cand_q;
    have_act_d   = have_act_q;
    h_act_cand_d = h_act_cand_q;
    if (hs_edge && (v_cnt_q == '0))
      h_cand_d = h_cnt_q;
    if (line_has_act && !have_act_q) begin
      have_act_d   = 1'b1;
      h_act_cand_d = act_cnt_q;
    end
    if (vs_edge) begin
      h_cand_d     = '0;
      have_act_d   = 1'b0;
      h_act_cand_d = '0;
    end
    crc_d = vs_edge ? 16'hFFFF : fin_crc;
  end

  logic publish, store_ref;

  always_comb begin
    state_d        = state_q;
    publish        = 1'b0;
    store_ref      = 1'b0;
    frame_done_d   = 1'b0;
    locked_d       = locked_q;
    timing_error_d = timing_error_q;
    frame_count_d  = frame_count_q;
    h_total_d      = h_total_q;
    h_active_d     = h_active_q;
    v_total_d      = v_total_q;
    v_active_d     = v_active_q;
    frame_crc_d    = frame_crc_q;
    ref_h_total_d  = ref_h_total_q;
    ref_h_active_d = ref_h_active_q;
    ref_v_total_d  = ref_v_total_q;
    ref_v_active_d = ref_v_active_q;
    ref_bad_d      = ref_bad_q;
    if (!enable) begin
      state_d  = SEARCH;
      locked_d = 1'b0;
    end else if (vs_edge) begin
      case (state_q)
        SEARCH:  state_d = MEASURE;
        MEASURE: begin
          publish   = 1'b1;
          store_ref = 1'b1;
          state_d   = CONFIRM;
        end
        CONFIRM: begin
          publish = 1'b1;
          if (matches_ref) begin
            locked_d      = 1'b1;
            frame_count_d = 16'd1;
            state_d       = LOCKED;
          end else begin
            store_ref = 1'b1;
          end
        end
        LOCKED: begin
          publish       = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          if (!matches_ref) begin
            timing_error_d = 1'b1;
            locked_d       = 1'b0;
            store_ref      = 1'b1;
            state_d        = CONFIRM;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (publish) begin
      frame_done_d = 1'b1;
      h_total_d    = fin_h_total;
      h_active_d   = fin_h_active;
      v_total_d    = fin_v_total;
      v_active_d   = fin_v_active;
      frame_crc_d  = fin_crc;
    end
    if (store_ref) begin
      ref_h_total_d  = fin_h_total;
      ref_h_active_d = fin_h_active;
      ref_v_total_d  = fin_v_total;
      ref_v_active_d = fin_v_active;
      ref_bad_d      = fin_bad;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEARCH;
      h_cnt_q        <= '0;
      act_cnt_q      <= '0;
      h_cand_q       <= '0;
      h_act_cand_q   <= '0;
      have_act_q     <= 1'b0;
      irregular_q    <= 1'b0;
      v_cnt_q        <= '0;
      v_act_q        <= '0;
      crc_q          <= 16'hFFFF;
      ref_h_total_q  <= '0;
      ref_h_active_q <= '0;
      ref_v_total_q  <= '0;
      ref_v_active_q <= '0;
      ref_bad_q      <= 1'b1;
      h_total_q      <= '0;
      h_active_q     <= '0;
      v_total_q      <= '0;
      v_active_q     <= '0;
      frame_crc_q    <= '0;
      frame_count_q  <= '0;
      frame_done_q   <= 1'b0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_cnt_q        <= h_cnt_d;
      act_cnt_q      <= act_cnt_d;
      h_cand_q       <= h_cand_d;
      h_act_cand_q   <= h_act_cand_d;
      have_act_q     <= have_act_d;
      irregular_q    <= irregular_d;
      v_cnt_q        <= v_cnt_d;
      v_act_q        <= v_act_d;
      crc_q          <= crc_d;
      ref_h_total_q  <= ref_h_total_d;
      ref_h_active_q <= ref_h_active_d;
      ref_v_total_q  <= ref_v_total_d;
      ref_v_active_q <= ref_v_active_d;
      ref_bad_q      <= ref_bad_d;
      h_total_q      <= h_total_d;
      h_active_q     <= h_active_d;
      v_total_q      <= v_total_d;
      v_active_q     <= v_active_d;
      frame_crc_q    <= frame_crc_d;
      frame_count_q  <= frame_count_d;
      frame_done_q   <= frame_done_d;
      locked_q       <= locked_d;
      timing_error_q <= timing_error_d;
    end
  end

  assign h_total      = h_total_q;
  assign h_active     = h_active_q;
  assign v_total      = v_total_q;
  assign v_active     = v_active_q;
  assign frame_crc    = frame_crc_q;
  assign frame_count  = frame_count_q;
  assign frame_done   = frame_done_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;

endmodule

// File: tb/tb_video_frame_monitor.sv
// Directed bench for video_frame_monitor: an 8x6 frame (12x9 total) drives a default
// instance and an active-high-sync 4x8-bit instance side by side.
module tb_video_frame_monitor;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] pixel;
  logic        hsync, vsync, hblank, vblank;
  logic [31:0] pixel1;
  logic        hsync1, vsync1;

  logic [11:0] h_total0, h_active0;
  logic [10:0] v_total0, v_active0;
  logic [15:0] frame_crc0, frame_count0;
  logic        frame_done0, locked0, timing_error0;
  logic [11:0] h_total1, h_active1;
  logic [10:0] v_total1, v_active1;
  logic [15:0] frame_crc1, frame_count1;
  logic        frame_done1, locked1, timing_error1;

  int tests_run = 0;
  int tests_failed = 0;
  int done0 = 0;
  int done1 = 0;
  int d0, d1;
  logic watch_lock = 1'b0;
  logic lock_seen = 1'b0;
  logic [15:0] crc_zero_obs;

  assign pixel1 = {20'h00000, pixel};
  assign hsync1 = ~hsync;
  assign vsync1 = ~vsync;

  always #5 pixel_clk = ~pixel_clk;

  video_frame_monitor dut0 (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .enable(enable), .pixel(pixel),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .h_total(h_total0), .h_active(h_active0), .v_total(v_total0), .v_active(v_active0),
    .frame_crc(frame_crc0), .frame_count(frame_count0), .frame_done(frame_done0),
    .locked(locked0), .timing_error(timing_error0)
  );

  video_frame_monitor #(
    .C_COMPONENT_DEPTH(8), .C_CHANNELS(4), .C_HSYNC_ACTIVE(1), .C_VSYNC_ACTIVE(1)
  ) dut1 (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .enable(enable), .pixel(pixel1),
    .hsync(hsync1), .vsync(vsync1), .hblank(hblank), .vblank(vblank),
    .h_total(h_total1), .h_active(h_active1), .v_total(v_total1), .v_active(v_active1),
    .frame_crc(frame_crc1), .frame_count(frame_count1), .frame_done(frame_done1),
    .locked(locked1), .timing_error(timing_error1)
  );

  always @(negedge pixel_clk) begin
    if (frame_done0) done0++;
    if (frame_done1) done1++;
    if (watch_lock && (locked0 || locked1)) lock_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic hs, input logic vs, input logic hb, input logic vb,
                               input logic [11:0] px);
    hsync  = hs;
    vsync  = vs;
    hblank = hb;
    vblank = vb;
    pixel  = px;
    @(posedge pixel_clk);
    #1;
  endtask

  // hsync active low on cycles 9-10, vsync active low on row 7, active area rows 0-5 x cols 0-7.
  task automatic driveCycle(input int row, input int c, input logic [11:0] spot, input logic hs_hold);
    applyStimulus(hs_hold ? 1'b1 : !((c == 9) || (c == 10)), row != 7, c >= 8, row >= 6,
                  (row == 0 && c == 0) ? spot : 12'h000);
  endtask

  task automatic driveLine(input int row, input int len, input logic [11:0] spot, input logic hs_hold);
    for (int c = 0; c < len; c++) driveCycle(row, c, spot, hs_hold);
  endtask

  task automatic driveFrame(input logic [11:0] spot, input int long_row, input logic hs_hold);
    for (int row = 0; row < 9; row++)
      driveLine(row, (row == long_row) ? 13 : 12, spot, hs_hold);
  endtask

  function automatic logic [15:0] crcModel(input logic [11:0] spot, input int nbits);
    logic [15:0] crc;
    logic        b, fb;
    crc = 16'hFFFF;
    for (int p = 0; p < 48; p++) begin
      for (int i = nbits - 1; i >= 0; i--) begin
        b   = (p == 0 && i < 12) ? spot[i] : 1'b0;
        fb  = crc[15] ^ b;
        crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return crc;
  endfunction

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    hsync = 1'b1; vsync = 1'b1; hblank = 1'b1; vblank = 1'b1; pixel = 12'h000;
    repeat (3) @(posedge pixel_clk);
    #1;
    checkOutput("rst_h_total", 32'(h_total0), 32'd0);
    checkOutput("rst_v_total", 32'(v_total0), 32'd0);
    checkOutput("rst_crc", 32'(frame_crc0), 32'd0);
    checkOutput("rst_locked", 32'(locked0), 32'd0);
    checkOutput("rst_done", 32'(frame_done0), 32'd0);
    rst_n = 1'b1;

    // Nominal timing: lock on the third vsync, frame_count 2 after the fourth.
    d0 = done0; driveFrame(12'h000, -1, 1'b0);
    checkOutput("f0_done", 32'(done0 - d0), 32'd0);
    d0 = done0; driveFrame(12'h000, -1, 1'b0);
    checkOutput("f1_done", 32'(done0 - d0), 32'd1);
    checkOutput("f1_locked", 32'(locked0), 32'd0);
    checkOutput("f1_h_total", 32'(h_total0), 32'd12);
    d0 = done0; driveFrame(12'h000, -1, 1'b0);
    checkOutput("f2_done", 32'(done0 - d0), 32'd1);
    checkOutput("f2_locked", 32'(locked0), 32'd1);
    checkOutput("f2_count", 32'(frame_count0), 32'd1);
    d0 = done0; d1 = done1; driveFrame(12'h000, -1, 1'b0);
    checkOutput("f3_done", 32'(done0 - d0), 32'd1);
    checkOutput("f3_locked", 32'(locked0), 32'd1);
    checkOutput("f3_h_total", 32'(h_total0), 32'd12);
    checkOutput("f3_h_active", 32'(h_active0), 32'd8);
    checkOutput("f3_v_total", 32'(v_total0), 32'd9);
    checkOutput("f3_v_active", 32'(v_active0), 32'd6);
    checkOutput("f3_count", 32'(frame_count0), 32'd2);
    checkOutput("pol_done", 32'(done1 - d1), 32'd1);
    checkOutput("pol_locked", 32'(locked1), 32'd1);
    checkOutput("pol_h_total", 32'(h_total1), 32'd12);
    checkOutput("pol_h_active", 32'(h_active1), 32'd8);
    checkOutput("pol_v_total", 32'(v_total1), 32'd9);
    checkOutput("pol_v_active", 32'(v_active1), 32'd6);
    checkOutput("pol_count", 32'(frame_count1), 32'd2);

    // CRC over all-zero frame versus a frame with one full-scale pixel at (0,0).
    driveFrame(12'h000, -1, 1'b0);
    crc_zero_obs = frame_crc0;
    checkOutput("crc_zero", 32'(frame_crc0), 32'(crcModel(12'h000, 12)));
    checkOutput("crc_zero_w32", 32'(frame_crc1), 32'(crcModel(12'h000, 32)));
    driveFrame(12'hFFF, -1, 1'b0);
    checkOutput("crc_spot", 32'(frame_crc0), 32'(crcModel(12'hFFF, 12)));
    checkOutput("crc_spot_w32", 32'(frame_crc1), 32'(crcModel(12'hFFF, 32)));
    checkOutput("crc_differs", 32'(frame_crc0 != crc_zero_obs), 32'd1);
    checkOutput("crc_no_terr", 32'(timing_error0), 32'd0);
    checkOutput("crc_locked", 32'(locked0), 32'd1);

    // One 13-cycle line breaks lock; two nominal frames restore it.
    d0 = done0; driveFrame(12'h000, 2, 1'b0);
    checkOutput("long_done", 32'(done0 - d0), 32'd1);
    checkOutput("long_terr", 32'(timing_error0), 32'd1);
    checkOutput("long_locked", 32'(locked0), 32'd0);
    checkOutput("long_terr_pol", 32'(timing_error1), 32'd1);
    driveFrame(12'h000, -1, 1'b0);
    checkOutput("relock1_locked", 32'(locked0), 32'd0);
    driveFrame(12'h000, -1, 1'b0);
    checkOutput("relock2_locked", 32'(locked0), 32'd1);
    checkOutput("relock2_terr", 32'(timing_error0), 32'd1);

    // Asynchronous reset in the middle of a frame.
    for (int row = 0; row < 3; row++) driveLine(row, 12, 12'h000, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_locked", 32'(locked0), 32'd0);
    checkOutput("mrst_terr", 32'(timing_error0), 32'd0);
    checkOutput("mrst_count", 32'(frame_count0), 32'd0);
    checkOutput("mrst_h_total", 32'(h_total0), 32'd0);
    checkOutput("mrst_h_active", 32'(h_active0), 32'd0);
    checkOutput("mrst_v_active", 32'(v_active0), 32'd0);
    checkOutput("mrst_crc", 32'(frame_crc0), 32'd0);
    checkOutput("mrst_locked_pol", 32'(locked1), 32'd0);
    for (int c = 0; c < 12; c++) begin
      driveCycle(3, c, 12'h000, 1'b0);
      if (c == 2) rst_n = 1'b1;
    end
    for (int row = 4; row < 9; row++) driveLine(row, 12, 12'h000, 1'b0);
    repeat (3) driveFrame(12'h000, -1, 1'b0);
    checkOutput("mrst_relock", 32'(locked0), 32'd1);
    checkOutput("mrst_relock_count", 32'(frame_count0), 32'd2);

    // hsync never active: horizontal count saturates and lock must never occur.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
    rst_n = 1'b1;
    watch_lock = 1'b1;
    for (int f = 0; f < 40; f++) begin
      d0 = done0;
      driveFrame(12'h000, -1, 1'b1);
    end
    checkOutput("sat_done", 32'(done0 - d0), 32'd1);
    checkOutput("sat_h_total", 32'(h_total0), 32'hFFF);
    checkOutput("sat_h_total_pol", 32'(h_total1), 32'hFFF);
    checkOutput("sat_v_total", 32'(v_total0), 32'd0);
    checkOutput("sat_no_lock", 32'(lock_seen), 32'd0);
    watch_lock = 1'b0;

    // Disabled monitor stays in SEARCH: no frame_done, outputs held.
    enable = 1'b0;
    d0 = done0;
    driveFrame(12'h000, -1, 1'b0);
    driveFrame(12'h000, -1, 1'b0);
    checkOutput("dis_done", 32'(done0 - d0), 32'd0);
    checkOutput("dis_locked", 32'(locked0), 32'd0);
    checkOutput("dis_h_held", 32'(h_total0), 32'hFFF);
    enable = 1'b1;
    d0 = done0;
    driveFrame(12'h000, -1, 1'b0);
    checkOutput("reen_search_done", 32'(done0 - d0), 32'd0);
    d0 = done0;
    driveFrame(12'h000, -1, 1'b0);
    checkOutput("reen_measure_done", 32'(done0 - d0), 32'd1);
    checkOutput("reen_h_total", 32'(h_total0), 32'd12);
    checkOutput("reen_v_total", 32'(v_total0), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/video_frame_monitor.md
Name: video_frame_monitor

Overview:
Synthesisable, parametrised successor to the bench-only VGA logger. It sits on the system86 video output bus (pixel clock domain). For every frame it measures sync and blanking timing, counts frames, and computes a CRC over the active pixels. Benches and on-board self-test compare these against golden values instead of diffing dump files. Channel count, component depth, sync polarity and counter widths are generic.

Parameters:
C_COMPONENT_DEPTH, 4, bits per colour component
C_CHANNELS, 3, number of colour components packed in pixel bus (channel 0 in LSBs)
C_HCOUNT_WIDTH, 12, width of horizontal measurement counters
C_VCOUNT_WIDTH, 11, width of vertical measurement counters
C_HSYNC_ACTIVE, 0, active level of hsync
C_VSYNC_ACTIVE, 0, active level of vsync

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  monitor enable; 0 holds state machine in SEARCH
pixel  in  C_CHANNELS*C_COMPONENT_DEPTH  packed pixel data
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
hblank  in  1  horizontal blank, active high
vblank  in  1  vertical blank, active high
h_total  out  C_HCOUNT_WIDTH  pixel_clk cycles per line
h_active  out  C_HCOUNT_WIDTH  unblanked pixels on first active line
v_total  out  C_VCOUNT_WIDTH  lines per frame
v_active  out  C_VCOUNT_WIDTH  lines containing at least one unblanked pixel
frame_crc  out  16  CRC of active pixels of last completed frame
frame_count  out  16  completed frames since lock, wraps at 0xFFFF->0
frame_done  out  1  one-cycle pulse when outputs update
locked  out  1  timing identical for two consecutive frames
timing_error  out  1  sticky; set on mismatch while locked

Behaviour:
- Reset: all outputs 0, state SEARCH, internal CRC = 0xFFFF. Reset mid-frame fully aborts; the next frame is treated as first-seen.
- Sync edges: inputs are registered once. "hs_edge"/"vs_edge" is the registered transition from inactive to active level per C_*_ACTIVE. Detection latency is 1 cycle.
- Line counter: increments every cycle and loads 1 on hs_edge. On hs_edge the previous count is h_total candidate.
- Active pixel = hblank==0 && vblank==0. The per-line active count is captured on hs_edge for the first line of the frame with a nonzero count.
- Line count: increments on hs_edge and resets on vs_edge. The v_active counter increments on hs_edge if the closing line had a nonzero active count.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final xor.
  - Each active pixel word is shifted in MSB-first in a single cycle (unrolled).
  - Reinitialised on vs_edge.
- States:
  - SEARCH: wait for vs_edge with enable=1 -> MEASURE (counters cleared).
  - MEASURE: on next vs_edge, latch candidates into outputs, pulse frame_done, store as reference -> CONFIRM.
  - CONFIRM: on vs_edge, if candidates equal reference, set locked=1 and frame_count=1 -> LOCKED. Otherwise update outputs/reference, pulse frame_done, and stay.
  - LOCKED: on each vs_edge, update outputs, pulse frame_done and increment frame_count. On any timing mismatch, set timing_error, clear locked and go -> CONFIRM. A CRC change alone is not an error.
- Output update and frame_done occur the cycle after the registered vs_edge: 2 cycles after the raw vsync edge.
- enable=0 in any state: go to SEARCH next cycle and clear locked. timing_error and last outputs are held.
- Counter saturation:
  - Line or horizontal counters saturate at all-ones; they do not wrap.
  - A saturated count is latched as is and always compares as mismatch.
- vs_edge and hs_edge in the same cycle: the line closes first, then the frame closes, so the coinciding line counts toward the ending frame.
- hsync held inactive for a whole frame: h_total reports the saturated value and no lock is achieved.

Test Plan:
1. Generate 4 frames of 8x6 timing:
   - Stimulus: h_total 12, hsync low cycles 9-10, v_total 9, vsync low on line 7, active 8x6, constant pixel 0x000.
   - Required: after frame 3, locked=1, h_total=12, h_active=8, v_total=9, v_active=6, frame_count=2.
   - Required: frame_done pulses exactly once per frame.
2. Same timing, all-zero pixels vs single pixel 0xFFF at (0,0):
   - Required: frame_crc differs, matches the bench CRC model, and timing_error stays 0.
3. While locked, lengthen one line to 13 cycles:
   - Required: timing_error=1 and locked=0 at that frame's frame_done.
   - Required: locked=1 again two frames after nominal timing returns.
4. Polarity check:
   - Stimulus: C_HSYNC_ACTIVE=1, C_VSYNC_ACTIVE=1, inverted syncs, 4 channels x 8 bits.
   - Required: identical timing results to case 1.
5. Assert rst_n=0 mid-frame 3 for 3 cycles:
   - Required: all outputs 0 immediately (async).
   - Required: locked=1 again after 3 further complete frames.
6. Hold hsync inactive:
   - Required: h_total saturates to 0xFFF and locked never asserts.
   - Stimulus follow-up: drop enable.
   - Required: state returns to SEARCH and no frame_done pulses occur.
